// File: rtl/mioc_pkg.sv
// mioc_pkg: shared state encodings, bank selects and refresh counter width for the DRAM sequencer
package mioc_pkg;
  localparam int REF_CNT_W = 7;
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ROW  = 3'd1,
    ST_COL  = 3'd2,
    ST_CAS  = 3'd3,
    ST_REF  = 3'd4
  } state_t;
  typedef enum logic {
    BANK_LO = 1'b0,
    BANK_HI = 1'b1
  } bank_t;
endpackage

// File: rtl/mioc_dram_seq_if.sv
// mioc_dram_seq_if: Z80 bus strobes, map decode and DRAM strobe outputs
interface mioc_dram_seq_if;
  logic BMREQ_N;
  logic BRD_N;
  logic N_BWR;
  logic BRFSH_N;
  logic RAMSEL_LO;
  logic RAMSEL_HI;
  logic RAS_N;
  logic MUX;
  logic CAS1_N;
  logic CAS2_N;
  logic RA7;
  modport master (
    output BMREQ_N, BRD_N, N_BWR, BRFSH_N, RAMSEL_LO, RAMSEL_HI,
    input  RAS_N, MUX, CAS1_N, CAS2_N, RA7
  );
  modport slave (
    input  BMREQ_N, BRD_N, N_BWR, BRFSH_N, RAMSEL_LO, RAMSEL_HI,
    output RAS_N, MUX, CAS1_N, CAS2_N, RA7
  );
endinterface

// File: rtl/mioc_refresh_ctr.sv
// mioc_refresh_ctr: 7-bit refresh row counter with RA7 extension toggled on wrap
module mioc_refresh_ctr
  import mioc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic inc,
  output logic ra7
);
  logic [REF_CNT_W-1:0] cnt;
  // count completed refreshes; RA7 flips on the same edge the counter wraps to 0
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      ra7 <= 1'b0;
    end else if (inc) begin
      cnt <= cnt + 1'b1;
      ra7 <= (&cnt) ? ~ra7 : ra7;
    end
endmodule

// File: rtl/mioc_dram_seq.sv
// mioc_dram_seq: RAS/MUX/CAS sequencer for two DRAM banks with Z80 refresh handling
module mioc_dram_seq
  import mioc_pkg::*;
(
  input  logic B_PHI,
  input  logic RESET,
  mioc_dram_seq_if.slave bus
);
  state_t state, nxt;
  bank_t  bank, nbank;
  logic   refresh, access, inc;
  assign refresh = !bus.BMREQ_N && !bus.BRFSH_N;
  assign access  = !bus.BMREQ_N && bus.BRFSH_N && (!bus.BRD_N || !bus.N_BWR) && (bus.RAMSEL_LO || bus.RAMSEL_HI);
  assign inc     = (state == ST_REF) && !refresh;
  // next state; requests are only evaluated in IDLE and refresh wins over an access
  always_comb begin
    nxt   = ST_IDLE;
    nbank = (state == ST_IDLE && !refresh && access) ? (bus.RAMSEL_LO ? BANK_LO : BANK_HI) : bank;
    case (state)
      ST_IDLE: nxt = refresh ? ST_REF : access ? ST_ROW : ST_IDLE;
      ST_ROW:  nxt = bus.BMREQ_N ? ST_IDLE : ST_COL;
      ST_COL:  nxt = bus.BMREQ_N ? ST_IDLE : ST_CAS;
      ST_CAS:  nxt = bus.BMREQ_N ? ST_IDLE : ST_CAS;
      ST_REF:  nxt = refresh ? ST_REF : ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end
  // state, bank latch and strobes registered together so strobes track the state entered
  always_ff @(posedge B_PHI or posedge RESET)
    if (RESET) begin
      state      <= ST_IDLE;
      bank       <= BANK_LO;
      bus.RAS_N  <= 1'b1;
      bus.MUX    <= 1'b0;
      bus.CAS1_N <= 1'b1;
      bus.CAS2_N <= 1'b1;
    end else begin
      state      <= nxt;
      bank       <= nbank;
      bus.RAS_N  <= nxt == ST_IDLE;
      bus.MUX    <= nxt == ST_COL || nxt == ST_CAS;
      bus.CAS1_N <= !(nxt == ST_CAS && nbank == BANK_LO);
      bus.CAS2_N <= !(nxt == ST_CAS && nbank == BANK_HI);
    end
  mioc_refresh_ctr u_ctr (
    .clk(B_PHI),
    .rst(RESET),
    .inc(inc),
    .ra7(bus.RA7)
  );
endmodule

// File: tb/tb_mioc_dram_seq.sv
// tb_mioc_dram_seq: vector table, refresh/reset sequences and random traffic against a reference model
module tb_mioc_dram_seq;
  logic B_PHI;
  logic RESET;
  int n_cmp = 0;
  int n_bad = 0;
  mioc_dram_seq_if bus();
  mioc_dram_seq dut (
    .B_PHI(B_PHI),
    .RESET(RESET),
    .bus(bus.slave)
  );
  initial B_PHI = 1'b0;
  always #5 B_PHI = ~B_PHI;
  localparam logic [5:0] IN_IDLE = 6'b111100;
  localparam logic [5:0] IN_RDLO = 6'b001110;
  localparam logic [5:0] IN_REF  = 6'b011000;
  localparam logic [4:0] O_IDLE  = 5'b10110;
  localparam logic [4:0] O_ROW   = 5'b00110;
  localparam logic [4:0] O_COL   = 5'b01110;
  localparam logic [4:0] O_CLO   = 5'b01010;
  localparam logic [4:0] O_CHI   = 5'b01100;
  localparam logic [4:0] O_REF   = 5'b00110;
  typedef struct packed {
    logic [5:0] in;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl [28];
  int  m_age;
  int  m_cnt;
  bit  m_ref;
  bit  m_bank;
  function automatic logic [4:0] outs();
    return {bus.RAS_N, bus.MUX, bus.CAS1_N, bus.CAS2_N, bus.RA7};
  endfunction
  function automatic logic [4:0] m_exp();
    return {!(m_ref || m_age > 0), m_age >= 2, !(m_age == 3 && !m_bank), !(m_age == 3 && m_bank), 1'((m_cnt >> 7) & 1)};
  endfunction
  task automatic model_reset();
    m_age = 0; m_cnt = 0; m_ref = 0; m_bank = 0;
  endtask
  task automatic model_step();
    logic mreq, rd, wr, rf, lo, hi;
    {mreq, rd, wr, rf, lo, hi} = {bus.BMREQ_N, bus.BRD_N, bus.N_BWR, bus.BRFSH_N, bus.RAMSEL_LO, bus.RAMSEL_HI};
    if (m_ref) begin
      if (!(!mreq && !rf)) begin m_ref = 0; m_cnt++; end
    end else if (m_age > 0) m_age = mreq ? 0 : (m_age < 3 ? m_age + 1 : 3);
    else if (!mreq && !rf) m_ref = 1;
    else if (!mreq && (!rd || !wr) && (lo || hi)) begin m_age = 1; m_bank = !lo; end
  endtask
  task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got {ras_n,mux,cas1_n,cas2_n,ra7}=%b expected %b", name, $time, act, exp);
    end
  endtask
  task automatic cyc(input logic [5:0] in);
    {bus.BMREQ_N, bus.BRD_N, bus.N_BWR, bus.BRFSH_N, bus.RAMSEL_LO, bus.RAMSEL_HI} = in;
    @(posedge B_PHI);
    model_step();
    #2;
  endtask
  task automatic do_reset();
    RESET = 1'b1;
    model_reset();
    #1;
    chk("reset_async", outs(), O_IDLE);
    {bus.BMREQ_N, bus.BRD_N, bus.N_BWR, bus.BRFSH_N, bus.RAMSEL_LO, bus.RAMSEL_HI} = IN_IDLE;
    @(posedge B_PHI);
    #2;
    RESET = 1'b0;
  endtask
  task automatic refreshes(input int n, input logic ra7_end);
    for (int i = 0; i < n; i++) begin
      cyc(IN_REF);
      chk("refresh_enter", outs(), m_exp());
      cyc(IN_IDLE);
      chk("refresh_exit", outs(), m_exp());
    end
    chk("refresh_ra7", outs(), {4'b1011, ra7_end});
  endtask
  initial begin
    tbl[0]  = '{IN_RDLO,   O_ROW};
    tbl[1]  = '{IN_RDLO,   O_COL};
    tbl[2]  = '{IN_RDLO,   O_CLO};
    tbl[3]  = '{IN_RDLO,   O_CLO};
    tbl[4]  = '{IN_IDLE,   O_IDLE};
    tbl[5]  = '{6'b010101, O_ROW};
    tbl[6]  = '{6'b010101, O_COL};
    tbl[7]  = '{6'b010101, O_CHI};
    tbl[8]  = '{6'b010100, O_CHI};
    tbl[9]  = '{IN_IDLE,   O_IDLE};
    tbl[10] = '{IN_RDLO,   O_ROW};
    tbl[11] = '{IN_IDLE,   O_IDLE};
    tbl[12] = '{6'b001010, O_REF};
    tbl[13] = '{6'b001010, O_REF};
    tbl[14] = '{IN_RDLO,   O_IDLE};
    tbl[15] = '{IN_RDLO,   O_ROW};
    tbl[16] = '{IN_IDLE,   O_IDLE};
    tbl[17] = '{6'b001111, O_ROW};
    tbl[18] = '{6'b001111, O_COL};
    tbl[19] = '{6'b001111, O_CLO};
    tbl[20] = '{IN_IDLE,   O_IDLE};
    tbl[21] = '{6'b001100, O_IDLE};
    tbl[22] = '{6'b011110, O_IDLE};
    tbl[23] = '{IN_REF,    O_REF};
    tbl[24] = '{6'b111000, O_IDLE};
    tbl[25] = '{IN_RDLO,   O_ROW};
    tbl[26] = '{IN_RDLO,   O_COL};
    tbl[27] = '{IN_IDLE,   O_IDLE};
    model_reset();
    RESET = 1'b1;
    {bus.BMREQ_N, bus.BRD_N, bus.N_BWR, bus.BRFSH_N, bus.RAMSEL_LO, bus.RAMSEL_HI} = IN_RDLO;
    #1;
    chk("reset_immediate", outs(), O_IDLE);
    repeat (2) @(posedge B_PHI);
    #2;
    chk("reset_hold", outs(), O_IDLE);
    {bus.BMREQ_N, bus.BRD_N, bus.N_BWR, bus.BRFSH_N, bus.RAMSEL_LO, bus.RAMSEL_HI} = IN_IDLE;
    RESET = 1'b0;
    for (int i = 0; i < 28; i++) begin
      cyc(tbl[i].in);
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end
    do_reset();
    refreshes(127, 1'b0);
    refreshes(1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cyc(IN_RDLO);
      chk("read_to_cas", outs(), m_exp());
    end
    chk("cas_before_reset", outs(), 5'b01011);
    do_reset();
    cyc(IN_RDLO);
    chk("first_after_reset", outs(), O_ROW);
    cyc(IN_IDLE);
    chk("idle_after_first", outs(), O_IDLE);
    refreshes(127, 1'b0);
    refreshes(1, 1'b1);
    refreshes(128, 1'b0);
    for (int i = 0; i < 3000; i++) begin
      logic [5:0] in;
      if ($urandom_range(0, 199) == 0) do_reset();
      in[5] = $urandom_range(0, 9) >= 7;
      in[4] = 1'($urandom);
      in[3] = 1'($urandom);
      in[2] = $urandom_range(0, 9) >= 2;
      in[1] = 1'($urandom);
      in[0] = 1'($urandom);
      cyc(in);
      chk("random", outs(), m_exp());
      chk("cas_exclusive", {4'b0000, !(!bus.CAS1_N && !bus.CAS2_N) && !(bus.RAS_N && (!bus.CAS1_N || !bus.CAS2_N))}, 5'b00001);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
